// File: rtl/conv1_requant_relu_writer_if.sv
// Control handshake between the conv1 sequencer and the requant/ReLU writer.
interface conv1_requant_relu_writer_if;
   logic start;
   logic relu_en;
   logic busy;
   logic done;

   modport master (output start, output relu_en, input busy, input done);
   modport slave  (input start, input relu_en, output busy, output done);
endinterface

// File: rtl/conv1_requant_relu_writer.sv
// Requantises the conv1 accumulator matrix (bias, scale, round-shift, ReLU, saturate)
// and scatters it into a channel-major activation map, one element per cycle.
module conv1_requant_relu_writer #(
   parameter int M_TOTAL  = 3136,
   parameter int N_TOTAL  = 64,
   parameter int H_OUT    = 56,
   parameter int W_OUT    = 56,
   parameter int MULT_W   = 16,
   parameter int SHIFT_W  = 5,
   parameter int DATA_W_P = 8,
   parameter int ACC_W_P  = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   conv1_requant_relu_writer_if.slave  ctrl,
   input  logic signed [ACC_W_P-1:0]   C_full [M_TOTAL][N_TOTAL],
   input  logic signed [ACC_W_P-1:0]   bias   [N_TOTAL],
   input  logic signed [MULT_W-1:0]    mult   [N_TOTAL],
   input  logic        [SHIFT_W-1:0]   shift  [N_TOTAL],
   output logic signed [DATA_W_P-1:0]  fmap_o [N_TOTAL][H_OUT][W_OUT]
);
   localparam int MW = (M_TOTAL > 1) ? $clog2(M_TOTAL) : 1;
   localparam int NW = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1;
   localparam int HW = (H_OUT   > 1) ? $clog2(H_OUT)   : 1;
   localparam int WW = (W_OUT   > 1) ? $clog2(W_OUT)   : 1;
   localparam int SW = ACC_W_P + 1;
   localparam int PW = ACC_W_P + 1 + MULT_W;
   localparam logic signed [PW:0] MAXV = (PW+1)'((64'sd1 <<< (DATA_W_P-1)) - 64'sd1);
   localparam logic signed [PW:0] MINV = ~MAXV;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state;
   logic [1:0]      drain_cnt;
   logic            relu_q, busy_q, done_q;
   logic [MW-1:0]   m;
   logic [NW-1:0]   n;
   logic [HW-1:0]   oh;
   logic [WW-1:0]   ow;
   logic            last;

   assign last      = (m == MW'(M_TOTAL-1)) && (n == NW'(N_TOTAL-1));
   assign ctrl.busy = busy_q;
   assign ctrl.done = done_q;

   // busy/done are registered off the state, so both trail it by one cycle:
   // done rises on the edge after S_DONE is left, together with busy falling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         relu_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         m <= '0; n <= '0; oh <= '0; ow <= '0;
      end else begin
         busy_q <= (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (ctrl.start) begin
                  relu_q <= ctrl.relu_en;
                  done_q <= 1'b0;
                  m <= '0; n <= '0; oh <= '0; ow <= '0;
                  state  <= S_RUN;
               end else if (busy_q) begin
                  done_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (last) begin
                  m <= '0; n <= '0; oh <= '0; ow <= '0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else if (n == NW'(N_TOTAL-1)) begin
                  n <= '0;
                  m <= m + MW'(1);
                  if (ow == WW'(W_OUT-1)) begin
                     ow <= '0;
                     oh <= oh + HW'(1);
                  end else begin
                     ow <= ow + WW'(1);
                  end
               end else begin
                  n <= n + NW'(1);
               end
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt + 2'd1;
               if (drain_cnt == 2'd2) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pipeline: vld_pipe[0] = S1 result valid, vld_pipe[1] = S2 result valid.
   logic [1:0]                vld_pipe;
   logic [NW-1:0]             n1, n2;
   logic [HW-1:0]             oh1, oh2;
   logic [WW-1:0]             ow1, ow2;
   logic signed [SW-1:0]      sum1;
   logic signed [MULT_W-1:0]  mult1;
   logic [SHIFT_W-1:0]        shift1, shift2;
   logic signed [PW-1:0]      prod2;

   // Per-channel operands are read only at S1 and travel with the element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         n1 <= '0; oh1 <= '0; ow1 <= '0; sum1 <= '0; mult1 <= '0; shift1 <= '0;
         n2 <= '0; oh2 <= '0; ow2 <= '0; prod2 <= '0; shift2 <= '0;
      end else begin
         vld_pipe[0] <= (state == S_RUN);
         n1     <= n;
         oh1    <= oh;
         ow1    <= ow;
         sum1   <= SW'(C_full[m][n]) + SW'(bias[n]);
         mult1  <= mult[n];
         shift1 <= shift[n];

         vld_pipe[1] <= vld_pipe[0];
         n2     <= n1;
         oh2    <= oh1;
         ow2    <= ow1;
         prod2  <= PW'(sum1) * PW'(mult1);
         shift2 <= shift1;
      end
   end

   // One extra bit of headroom so the rounding add cannot wrap.
   logic signed [PW:0]       rnd, r;
   logic signed [DATA_W_P-1:0] res;

   always_comb begin
      rnd = (PW+1)'(prod2);
      if (shift2 != '0) rnd = rnd + ((PW+1)'(1) <<< (shift2 - SHIFT_W'(1)));
      r = rnd >>> shift2;
      if (relu_q && r[PW]) r = '0;
      if (r > MAXV)      res = MAXV[DATA_W_P-1:0];
      else if (r < MINV) res = MINV[DATA_W_P-1:0];
      else               res = r[DATA_W_P-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TOTAL; i++)
            for (int j = 0; j < H_OUT; j++)
               for (int k = 0; k < W_OUT; k++)
                  fmap_o[i][j][k] <= '0;
      end else if (vld_pipe[1]) begin
         fmap_o[n2][oh2][ow2] <= res;
      end
   end
endmodule

// File: tb/tb_conv1_requant_relu_writer.sv
// Directed bench for the conv1 requant writer on a 2x2x2 map with 8-bit output.
module tb_conv1_requant_relu_writer;
   localparam int M = 4, N = 2, H = 2, W = 2;
   localparam int DW = 8, AW = 32, MLW = 16, SHW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv1_requant_relu_writer_if ctrl();

   logic signed [AW-1:0]  C_full [M][N];
   logic signed [AW-1:0]  bias   [N];
   logic signed [MLW-1:0] mult   [N];
   logic        [SHW-1:0] shift  [N];
   logic signed [DW-1:0]  fmap_o [N][H][W];

   int checks = 0;
   int errors = 0;

   conv1_requant_relu_writer #(
      .M_TOTAL(M), .N_TOTAL(N), .H_OUT(H), .W_OUT(W),
      .MULT_W(MLW), .SHIFT_W(SHW), .DATA_W_P(DW), .ACC_W_P(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ctrl(ctrl),
      .C_full(C_full), .bias(bias), .mult(mult), .shift(shift), .fmap_o(fmap_o)
   );

   task automatic clear_inputs();
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) C_full[m][n] = '0;
      for (int n = 0; n < N; n++) begin
         bias[n] = '0; mult[n] = '0; shift[n] = '0;
      end
   endtask

   // Pulses start, then counts edges until done; optionally re-pulses start mid-pass.
   task automatic run_pass(input logic relu, input int glitch_at,
                           output int edges, output int busy_cyc);
      edges = 0;
      busy_cyc = 0;
      @(negedge clk);
      ctrl.start = 1'b1;
      ctrl.relu_en = relu;
      @(posedge clk); #1;
      ctrl.start = 1'b0;
      checks++;
      if (ctrl.done !== 1'b0) begin
         errors++;
         $display("FAIL done_clear_on_accept got %0b exp 0", ctrl.done);
      end
      while (edges < 100) begin
         @(posedge clk); #1;
         edges++;
         ctrl.start = (edges == glitch_at);
         ctrl.relu_en = (edges == glitch_at) ? ~relu : relu;
         if (ctrl.busy === 1'b1) busy_cyc++;
         if (ctrl.done === 1'b1) break;
      end
      ctrl.start = 1'b0;
      ctrl.relu_en = relu;
      checks++;
      if (edges >= 100) begin
         errors++;
         $display("FAIL pass_timeout got %0d edges exp done within 100", edges);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%0b done=%0b exp 0 0", ctrl.busy, ctrl.done);
      end
      for (int n = 0; n < N; n++)
         for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++) begin
               checks++;
               if (fmap_o[n][h][w] !== 8'sd0) begin
                  errors++;
                  $display("FAIL reset_fmap[%0d][%0d][%0d] got %0d exp 0", n, h, w, fmap_o[n][h][w]);
               end
            end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_requant();
      clear_inputs();
      bias[0] = 28;  mult[0] = 16384; shift[0] = 15;
      bias[1] = 0;   mult[1] = 16384; shift[1] = 14;
      C_full[0][0] = 100;
      C_full[0][1] = -3;
      C_full[1][1] = -500;
      C_full[2][1] = 10000;
   endtask

   task automatic test_requant_relu();
      int e, b;
      load_requant();
      run_pass(1'b1, 0, e, b);
      checks++;
      if (fmap_o[0][0][0] !== 8'sd64) begin
         errors++; $display("FAIL relu_round_half got %0d exp 64", fmap_o[0][0][0]);
      end
      checks++;
      if (fmap_o[1][0][1] !== 8'sd0) begin
         errors++; $display("FAIL relu_clamp_neg got %0d exp 0", fmap_o[1][0][1]);
      end
      checks++;
      if (fmap_o[1][1][0] !== 8'sd127) begin
         errors++; $display("FAIL relu_pos_sat got %0d exp 127", fmap_o[1][1][0]);
      end
      checks++;
      if (fmap_o[0][1][1] !== 8'sd14) begin
         errors++; $display("FAIL relu_bias_only got %0d exp 14", fmap_o[0][1][1]);
      end
   endtask

   task automatic test_requant_norelu();
      int e, b;
      load_requant();
      run_pass(1'b0, 0, e, b);
      checks++;
      if (fmap_o[1][0][1] !== -8'sd128) begin
         errors++; $display("FAIL norelu_neg_sat got %0d exp -128", fmap_o[1][0][1]);
      end
      checks++;
      if (fmap_o[1][0][0] !== -8'sd3) begin
         errors++; $display("FAIL norelu_neg_round got %0d exp -3", fmap_o[1][0][0]);
      end
      checks++;
      if (fmap_o[0][0][0] !== 8'sd64) begin
         errors++; $display("FAIL norelu_pos got %0d exp 64", fmap_o[0][0][0]);
      end
   endtask

   task automatic test_no_round();
      int e, b;
      clear_inputs();
      mult[0] = 1; shift[0] = 0;
      mult[1] = 1; shift[1] = 1;
      C_full[0][0] = -3;
      C_full[0][1] = -3;
      C_full[1][1] = 5;
      C_full[2][0] = -200;
      C_full[3][1] = -1;
      run_pass(1'b0, 0, e, b);
      checks++;
      if (fmap_o[0][0][0] !== -8'sd3) begin
         errors++; $display("FAIL shift0_passthru got %0d exp -3", fmap_o[0][0][0]);
      end
      checks++;
      if (fmap_o[1][0][0] !== -8'sd1) begin
         errors++; $display("FAIL shift1_neg got %0d exp -1", fmap_o[1][0][0]);
      end
      checks++;
      if (fmap_o[1][0][1] !== 8'sd3) begin
         errors++; $display("FAIL shift1_pos got %0d exp 3", fmap_o[1][0][1]);
      end
      checks++;
      if (fmap_o[0][1][0] !== -8'sd128) begin
         errors++; $display("FAIL shift0_neg_sat got %0d exp -128", fmap_o[0][1][0]);
      end
      checks++;
      if (fmap_o[1][1][1] !== 8'sd0) begin
         errors++; $display("FAIL shift1_round_to_zero got %0d exp 0", fmap_o[1][1][1]);
      end
   endtask

   task automatic load_layout(input int offset);
      clear_inputs();
      for (int n = 0; n < N; n++) begin
         mult[n] = 1; shift[n] = 0;
      end
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) C_full[m][n] = m * 10 + n + offset;
   endtask

   task automatic check_layout(input int offset, input string tag);
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) begin
            checks++;
            if (fmap_o[n][m / W][m % W] !== DW'(m * 10 + n + offset)) begin
               errors++;
               $display("FAIL %s[%0d][%0d][%0d] got %0d exp %0d", tag, n, m / W, m % W,
                        fmap_o[n][m / W][m % W], m * 10 + n + offset);
            end
         end
   endtask

   task automatic test_layout_latency();
      int e, b;
      load_layout(0);
      run_pass(1'b1, 0, e, b);
      checks++;
      if (e !== 13) begin
         errors++; $display("FAIL done_latency got %0d edges exp 13", e);
      end
      checks++;
      if (b !== 12) begin
         errors++; $display("FAIL busy_cycles got %0d exp 12", b);
      end
      check_layout(0, "layout");
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (ctrl.done !== 1'b1 || ctrl.busy !== 1'b0) begin
         errors++;
         $display("FAIL done_sticky got done=%0b busy=%0b exp 1 0", ctrl.done, ctrl.busy);
      end
   endtask

   task automatic test_start_ignored();
      int e, b;
      load_layout(1);
      run_pass(1'b0, 3, e, b);
      checks++;
      if (e !== 13) begin
         errors++; $display("FAIL start_ignored_len got %0d edges exp 13", e);
      end
      check_layout(1, "restart_layout");
   endtask

   task automatic test_reset_mid();
      int e, b;
      load_layout(2);
      @(negedge clk);
      ctrl.start = 1'b1;
      ctrl.relu_en = 1'b0;
      @(negedge clk);
      ctrl.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctrl.busy !== 1'b0 || ctrl.done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_flags got busy=%0b done=%0b exp 0 0", ctrl.busy, ctrl.done);
      end
      for (int n = 0; n < N; n++)
         for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++) begin
               checks++;
               if (fmap_o[n][h][w] !== 8'sd0) begin
                  errors++;
                  $display("FAIL midreset_fmap[%0d][%0d][%0d] got %0d exp 0", n, h, w, fmap_o[n][h][w]);
               end
            end
      @(negedge clk);
      rst_n = 1'b1;
      run_pass(1'b0, 0, e, b);
      checks++;
      if (e !== 13) begin
         errors++; $display("FAIL post_reset_len got %0d edges exp 13", e);
      end
      check_layout(2, "post_reset");
   endtask

   initial begin
      ctrl.start = 1'b0;
      ctrl.relu_en = 1'b0;
      clear_inputs();
      test_reset();
      test_requant_relu();
      test_requant_norelu();
      test_no_round();
      test_layout_latency();
      test_start_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv1_requant_relu_writer.md
Name: conv1_requant_relu_writer

Overview:
- Sits directly downstream of the conv1 GEMM controller.
- Consumes the conv1 accumulator matrix C_full[M_TOTAL][N_TOTAL] (row m = output pixel oh*W_OUT+ow, column n = output channel).
- Applies per-channel bias, fixed-point multiply, round-shift, optional ReLU and saturation.
- Scatters results into a channel-major activation map fmap_o[N_TOTAL][H_OUT][W_OUT] in DATA_W for the next backbone stage.
- Processes one element per cycle through a 3-stage pipeline under a start/busy/sticky-done handshake.

Parameters:
M_TOTAL, 3136, rows of C_full (output pixels), must equal H_OUT*W_OUT
N_TOTAL, 64, columns of C_full (output channels)
H_OUT, 56, output map height
W_OUT, 56, output map width
MULT_W, 16, width of signed per-channel multiplier
SHIFT_W, 5, width of per-channel right-shift amount (0..31)
DATA_W_P, DATA_W (backbone_pkg), output activation width
ACC_W_P, ACC_W (backbone_pkg), accumulator width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in S_IDLE
relu_en  in  1  1 = clamp negatives to 0; sampled on accepted start, held for the pass
busy  out  1  high in S_RUN, S_DRAIN, S_DONE
done  out  1  sticky completion flag
C_full  in  signed ACC_W_P [M_TOTAL][N_TOTAL]  conv1 accumulators; must be stable while busy
bias  in  signed ACC_W_P [N_TOTAL]  per-channel bias added to accumulator
mult  in  signed MULT_W [N_TOTAL]  per-channel scale
shift  in  unsigned SHIFT_W [N_TOTAL]  per-channel arithmetic right shift
fmap_o  out  signed DATA_W_P [N_TOTAL][H_OUT][W_OUT]  registered output map

Behaviour:
- Reset (async, rst_n low): state S_IDLE, all counters 0, pipeline valids 0, busy 0, done 0, every fmap_o element 0. Reset mid-pass aborts immediately; no partial-pass resumption.
- FSM states:
  - S_IDLE: on start, latch relu_en, clear done, idx=0, go to S_RUN.
  - S_RUN: issue element idx each cycle, idx++. After issuing idx = M_TOTAL*N_TOTAL-1, go to S_DRAIN. Lasts exactly M_TOTAL*N_TOTAL cycles.
  - S_DRAIN: 3 cycles, no issue, pipeline flushes.
  - S_DONE: 1 cycle; set done on exit; return to S_IDLE.
- start is ignored outside S_IDLE. done stays high until the next accepted start; it clears on the edge that accepts start.
- Traversal order: m outer, n inner; idx = m*N_TOTAL + n. Use counters (m, n, oh, ow) with wrap rather than division.
  - n wraps at N_TOTAL and increments m.
  - ow wraps at W_OUT and increments oh.
- Pipeline (each stage carries valid, n, oh, ow):
  - S1: sum = C_full[m][n] + bias[n], computed at ACC_W_P+1 bits, no overflow loss.
  - S2: prod = sum * mult[n], full signed width ACC_W_P+1+MULT_W.
  - S3:
    - If shift>0: r = (prod + (1 << (shift-1))) >>> shift. If shift==0: r = prod.
    - If relu_en and r<0: r = 0.
    - Saturate to [-2^(DATA_W_P-1), 2^(DATA_W_P-1)-1].
    - Register into fmap_o[n][oh][ow].
- Latency: element issued at edge t is written at edge t+3. done rises M_TOTAL*N_TOTAL+5 edges after the start-accepting edge.
- Only addressed fmap_o elements change during a pass; all others hold their value. A new pass overwrites every element.
- Reads of C_full, bias, mult and shift are combinational at S1 only; inputs may change once busy falls.

Test Plan:
- Small config M_TOTAL=4, H_OUT=W_OUT=2, N_TOTAL=2, DATA_W=8. C_full[0][0]=100, bias[0]=28, mult[0]=16384, shift[0]=15, relu_en=1 -> fmap_o[0][0][0]=64.
- C_full[1][1]=-500, bias=0, mult=16384, shift=14: relu_en=1 -> fmap_o[1][0][1]=0; relu_en=0 -> -500 saturates to -128.
- C_full=10000, mult=16384, shift=14 -> 127 (positive saturation). shift=0, mult=1, C_full=-3, relu_en=0 -> -3 (no rounding add).
- Layout/latency: C_full[m][n]=m*10+n, bias=0, mult=1, shift=0 -> fmap_o[n][m/2][m%2]=m*10+n for all 8 entries; busy high 12 cycles; done asserts exactly 13 edges after start; done stays high; second start clears it on the accepting edge.
- start pulsed again while busy -> ignored, pass length unchanged. Async rst_n low mid-S_RUN -> busy=0, done=0, all fmap_o=0 immediately; a fresh start completes normally.
